sensor_digit_scanner: RTL and testbench
=======================================

Name: sensor_digit_scanner

Overview:
- Converts an 8-bit sensor reading to three BCD digits with a sequential double-dabble engine.
- Time-multiplexes the digits onto a shared 3-digit common-anode display.
- Sits directly upstream of the registered 7-segment decoder: drives the decoder's 8-bit value input one digit at a time, plus matching active-low digit enables.
- Digit enables are delayed one cycle so they line up with the decoder's registered segment output.

Parameters:
REFRESH_DIV, 50000, clock cycles each digit is displayed before advancing (must be >= 2)
CNT_W, 16, width of refresh counter (must hold REFRESH_DIV-1)
BLANK_LZ, 1, 1 = blank leading zeros in hundreds/tens positions; ones digit never blanked

Ports:
clk  input  1  system clock, all logic on rising edge
rst_n  input  1  synchronous active-low reset
sample_valid  input  1  one-cycle strobe: sample_value is a new reading
sample_value  input  8  unsigned reading, 0..255
busy  output  1  conversion in progress; sample_valid ignored while high
bcd_latched  output  12  displayed digits {hundreds, tens, ones}, 4 bits each
digit_value  output  8  current digit to decoder, zero-extended, range 0..9
digit_an  output  3  active-low digit enables, bit0 = ones, bit1 = tens, bit2 = hundreds

Behaviour:
- Reset: clk and active-low synchronous reset rst_n, sampled on rising edge only; no asynchronous paths. While rst_n = 0 at an edge, all of the following load and hold:
  - busy = 0, bcd_latched = 0, digit_value = 0, digit_an = 3'b111
  - FSM = IDLE, refresh counter = 0, digit index = 0 (ones)
- Reset mid-conversion aborts it; bcd_latched stays 0.
- Conversion FSM, states IDLE, SHIFT, LATCH:
  - IDLE: sample_valid = 1 at edge T loads a 20-bit shift register {12'b0, sample_value}, clears the iteration count, enters SHIFT; busy = 1 from after edge T.
  - SHIFT: each edge first adds 3 to any BCD nibble >= 5, then shifts the whole register left by 1. Runs 8 edges (T+1..T+8), then enters LATCH.
  - LATCH: edge T+9 copies the upper 12 bits to bcd_latched atomically, returns to IDLE, busy = 0.
  - Next sample is accepted at edge T+10 at the earliest.
- sample_valid while busy = 1 is dropped. No queueing and no effect on the conversion in flight.
- The scanner always reads bcd_latched, so a partial conversion is never displayed.
- Refresh counter:
  - Increments every cycle; at REFRESH_DIV-1 it wraps to 0 and the digit index advances 0 -> 1 -> 2 -> 0.
  - Runs independently of the FSM.
  - A LATCH coinciding with a wrap: the new digit index displays the new bcd_latched value on the following cycle.
- Output registers:
  - digit_value <= zero-extended nibble of bcd_latched selected by the digit index, one cycle after the index or bcd_latched changes.
  - digit_an <= one-hot-low of the index, delayed one further cycle relative to digit_value, matching the decoder's one-cycle register latency.
  - On an index change, the old enable stays asserted for exactly one cycle while the decoder output updates.
- Blanking when BLANK_LZ = 1:
  - hundreds = 0 forces digit_an[2] high.
  - hundreds = 0 and tens = 0 forces digit_an[1] high.
  - digit_value is still driven normally.
- Blanking when BLANK_LZ = 0: all three digits always enabled in turn.
- Exactly one bit of digit_an is low at any time after reset, except when that digit is blanked (all high).

Test Plan:
- Reset behaviour: hold rst_n = 0 for 3 cycles -> busy = 0, digit_an = 3'b111, digit_value = 0, bcd_latched = 0; release -> ones digit enabled (digit_an = 3'b110) two cycles later.
- Full-scale conversion: pulse sample_valid with 255 -> busy high exactly 9 cycles, bcd_latched = 12'h255; scanner (REFRESH_DIV = 4) presents digit_value 5, 5, 2 with digit_an 110, 101, 011, each 4 cycles, enable lagging digit_value by 1 cycle.
- Leading-zero blanking: BLANK_LZ = 1, sample 7 -> bcd_latched = 12'h007, only digit_an[0] ever low. Sample 40 -> tens and ones shown, hundreds blanked. Sample 100 -> all three shown, including zeros.
- Sample while busy: sample 128, then sample_valid with 99 three cycles later -> second dropped, bcd_latched = 12'h128. Sample 99 at T+10 -> 12'h099.
- Reset mid-operation: assert rst_n = 0 during SHIFT iteration 4 of sample 200 -> bcd_latched = 0, FSM IDLE, busy = 0; next sample 200 converts to 12'h200.
- Boundary values: samples 0, 9, 10, 99 -> bcd_latched = 12'h000, 12'h009, 12'h010, 12'h099; BLANK_LZ = 0 shows all digits including zeros.

Source files
------------

// File: rtl/sensor_digit_scanner_if.sv
// Sample/display bundle between the sensor front end and the digit scanner.
// The master side feeds readings and watches the display outputs.
interface sensor_digit_scanner_if;
  logic        sample_valid;
  logic [7:0]  sample_value;
  logic        busy;
  logic [11:0] bcd_latched;
  logic [7:0]  digit_value;
  logic [2:0]  digit_an;

  modport master (
    output sample_valid, sample_value,
    input  busy, bcd_latched, digit_value, digit_an
  );

  modport slave (
    input  sample_valid, sample_value,
    output busy, bcd_latched, digit_value, digit_an
  );
endinterface

// File: rtl/sensor_digit_scanner.sv
// 8-bit reading -> 3 BCD digits via sequential double-dabble, then time-multiplexed
// onto a common-anode display feeding a registered 7-segment decoder.
module sensor_digit_scanner #(
  parameter int unsigned REFRESH_DIV = 50000,
  parameter int unsigned CNT_W       = 16,
  parameter bit          BLANK_LZ    = 1'b1
) (
  input  logic                   clk,
  input  logic                   rst_n,
  sensor_digit_scanner_if.slave  bus
);

  typedef enum logic [1:0] {IDLE, SHIFT, LATCH} state_e;

  state_e            state_q, state_d;
  logic [19:0]       shreg_q, shreg_d;
  logic [2:0]        iter_q, iter_d;
  logic              busy_q, busy_d;
  logic [11:0]       bcd_q, bcd_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic [1:0]        idx_q, idx_d;
  logic [3:0]        dv_q, dv_d;
  logic [2:0]        an_pre_q, an_pre_d;
  logic [2:0]        an_q, an_d;
  logic [19:0]       adj;
  logic              wrap;

  always_comb begin
    state_d = state_q;
    shreg_d = shreg_q;
    iter_d  = iter_q;
    busy_d  = busy_q;
    bcd_d   = bcd_q;
    adj     = shreg_q;
    case (state_q)
      IDLE: begin
        if (bus.sample_valid) begin
          shreg_d = {12'b0, bus.sample_value};
          iter_d  = '0;
          state_d = SHIFT;
          busy_d  = 1'b1;
        end
      end
      SHIFT: begin
        // Add-3 correction on every BCD nibble precedes the shift within one edge.
        for (int unsigned n = 0; n < 3; n++) begin
          if (adj[8+4*n +: 4] >= 4'd5)
            adj[8+4*n +: 4] = adj[8+4*n +: 4] + 4'd3;
        end
        shreg_d = {adj[18:0], 1'b0};
        iter_d  = iter_q + 3'd1;
        if (iter_q == 3'd7)
          state_d = LATCH;
      end
      LATCH: begin
        bcd_d   = shreg_q[19:8];
        state_d = IDLE;
        busy_d  = 1'b0;
      end
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    wrap  = (cnt_q == CNT_W'(REFRESH_DIV - 1));
    cnt_d = wrap ? '0 : cnt_q + 1'b1;
    idx_d = idx_q;
    if (wrap)
      idx_d = (idx_q == 2'd2) ? 2'd0 : idx_q + 2'd1;

    // Enable is computed alongside the digit, then delayed once more to match the decoder.
    case (idx_q)
      2'd0: begin
        dv_d     = bcd_q[3:0];
        an_pre_d = 3'b110;
      end
      2'd1: begin
        dv_d     = bcd_q[7:4];
        an_pre_d = (BLANK_LZ && bcd_q[11:4] == 8'd0) ? 3'b111 : 3'b101;
      end
      default: begin
        dv_d     = bcd_q[11:8];
        an_pre_d = (BLANK_LZ && bcd_q[11:8] == 4'd0) ? 3'b111 : 3'b011;
      end
    endcase
    an_d = an_pre_q;
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q  <= IDLE;
      shreg_q  <= '0;
      iter_q   <= '0;
      busy_q   <= 1'b0;
      bcd_q    <= '0;
      cnt_q    <= '0;
      idx_q    <= '0;
      dv_q     <= '0;
      an_pre_q <= '1;
      an_q     <= '1;
    end else begin
      state_q  <= state_d;
      shreg_q  <= shreg_d;
      iter_q   <= iter_d;
      busy_q   <= busy_d;
      bcd_q    <= bcd_d;
      cnt_q    <= cnt_d;
      idx_q    <= idx_d;
      dv_q     <= dv_d;
      an_pre_q <= an_pre_d;
      an_q     <= an_d;
    end
  end

  assign bus.busy        = busy_q;
  assign bus.bcd_latched = bcd_q;
  assign bus.digit_value = {4'b0, dv_q};
  assign bus.digit_an    = an_q;

endmodule

// File: tb/tb_sensor_digit_scanner.sv
// Scoreboarded bench for sensor_digit_scanner: two instances (blanking on/off)
// share stimulus; a cycle model of the display tracks digits and enables.
module tb_sensor_digit_scanner;
  localparam int RD = 4;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic sv = 1'b0;
  logic [7:0] sval = 8'd0;

  always #5 clk = ~clk;

  sensor_digit_scanner_if if_b ();
  sensor_digit_scanner_if if_n ();

  assign if_b.sample_valid = sv;
  assign if_b.sample_value = sval;
  assign if_n.sample_valid = sv;
  assign if_n.sample_value = sval;

  sensor_digit_scanner #(.REFRESH_DIV(RD), .CNT_W(4), .BLANK_LZ(1'b1)) u_dut_b (
    .clk(clk), .rst_n(rst_n), .bus(if_b.slave));
  sensor_digit_scanner #(.REFRESH_DIV(RD), .CNT_W(4), .BLANK_LZ(1'b0)) u_dut_n (
    .clk(clk), .rst_n(rst_n), .bus(if_n.slave));

  int checks = 0;
  int failures = 0;
  logic [11:0] sb_q[$];

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0h exp=%0h at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic logic [11:0] bin2bcd(input int v);
    return {4'(v / 100), 4'((v / 10) % 10), 4'(v % 10)};
  endfunction

  function automatic logic [3:0] nib(input int idx, input logic [11:0] b);
    return (idx == 0) ? b[3:0] : (idx == 1) ? b[7:4] : b[11:8];
  endfunction

  function automatic logic [2:0] an_for(input int idx, input logic [11:0] b, input bit blank);
    if (idx == 0) return 3'b110;
    if (idx == 1) return (blank && b[11:4] == 8'd0) ? 3'b111 : 3'b101;
    return (blank && b[11:8] == 4'd0) ? 3'b111 : 3'b011;
  endfunction

  // Reference model, updated at each rising edge
  int          m_cnt, m_idx, m_busy_cnt;
  logic [11:0] m_bcd, m_pend;
  logic [3:0]  m_dv;
  logic [2:0]  m_anp_b, m_anp_n, m_an_b, m_an_n;
  logic        m_in_rst = 1'b1;
  logic        started = 1'b0;
  logic        prev_busy = 1'b0;

  always @(posedge clk) begin
    m_in_rst <= !rst_n;
    if (!rst_n) begin
      started    <= 1'b1;
      m_cnt      <= 0;
      m_idx      <= 0;
      m_busy_cnt <= 0;
      m_bcd      <= '0;
      m_pend     <= '0;
      m_dv       <= '0;
      m_anp_b    <= 3'b111;
      m_anp_n    <= 3'b111;
      m_an_b     <= 3'b111;
      m_an_n     <= 3'b111;
    end else begin
      if (m_busy_cnt == 0) begin
        if (sv) begin
          m_busy_cnt <= 9;
          m_pend     <= bin2bcd(int'(sval));
        end
      end else begin
        m_busy_cnt <= m_busy_cnt - 1;
        if (m_busy_cnt == 1) m_bcd <= m_pend;
      end
      m_cnt   <= (m_cnt == RD - 1) ? 0 : m_cnt + 1;
      if (m_cnt == RD - 1) m_idx <= (m_idx + 1) % 3;
      m_dv    <= nib(m_idx, m_bcd);
      m_anp_b <= an_for(m_idx, m_bcd, 1'b1);
      m_anp_n <= an_for(m_idx, m_bcd, 1'b0);
      m_an_b  <= m_anp_b;
      m_an_n  <= m_anp_n;
    end
  end

  logic [11:0] exp_bcd;
  always @(negedge clk) begin
    if (started) begin
      check("busy_b", {31'b0, if_b.busy}, {31'b0, m_busy_cnt != 0});
      check("busy_n", {31'b0, if_n.busy}, {31'b0, m_busy_cnt != 0});
      check("bcd_b", {20'b0, if_b.bcd_latched}, {20'b0, m_bcd});
      check("bcd_n", {20'b0, if_n.bcd_latched}, {20'b0, m_bcd});
      check("dv_b", {24'b0, if_b.digit_value}, {28'b0, m_dv});
      check("dv_n", {24'b0, if_n.digit_value}, {28'b0, m_dv});
      check("an_b", {29'b0, if_b.digit_an}, {29'b0, m_an_b});
      check("an_n", {29'b0, if_n.digit_an}, {29'b0, m_an_n});
      if (!m_in_rst && prev_busy && !if_b.busy) begin
        if (sb_q.size() == 0) begin
          check("sb_underflow", 32'(sb_q.size()), 32'd1);
        end else begin
          exp_bcd = sb_q.pop_front();
          check("sb_bcd_b", {20'b0, if_b.bcd_latched}, {20'b0, exp_bcd});
          check("sb_bcd_n", {20'b0, if_n.bcd_latched}, {20'b0, exp_bcd});
        end
      end
    end
    prev_busy <= if_b.busy;
  end

  // Called at a falling edge; holds the strobe across exactly one rising edge.
  task automatic drive_sample(input int v, input bit accepted);
    sv   = 1'b1;
    sval = 8'(v);
    if (accepted) sb_q.push_back(bin2bcd(v));
    @(negedge clk);
    sv = 1'b0;
  endtask

  task automatic wait_idle();
    int n = 0;
    while (if_b.busy && n < 50) begin
      @(negedge clk);
      n++;
    end
    if (if_b.busy) check("idle_timeout", {31'b0, if_b.busy}, 32'd0);
  endtask

  task automatic convert_and_show(input int v);
    drive_sample(v, 1'b1);
    wait_idle();
    repeat (3 * RD * 2 + 4) @(negedge clk);
  endtask

  initial begin
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    repeat (16) @(negedge clk);

    convert_and_show(255);
    convert_and_show(7);
    convert_and_show(40);
    convert_and_show(100);

    // Second strobe lands mid-conversion and must be dropped
    drive_sample(128, 1'b1);
    repeat (2) @(negedge clk);
    drive_sample(99, 1'b0);
    repeat (6) @(negedge clk);
    drive_sample(99, 1'b1);
    wait_idle();
    repeat (12) @(negedge clk);

    // Reset during the shift phase aborts the conversion
    drive_sample(200, 1'b1);
    repeat (3) @(negedge clk);
    rst_n = 1'b0;
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    sb_q.delete();
    repeat (4) @(negedge clk);
    convert_and_show(200);

    convert_and_show(0);
    convert_and_show(9);
    convert_and_show(10);
    convert_and_show(99);

    check("sb_empty", 32'(sb_q.size()), 32'd0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout reached at %0t", $time);
    $fatal(1, "timeout");
  end

endmodule
